// File: rtl/msg_encoder.sv
// msg_encoder
//   Message-to-polynomial expander for the encrypter datapath. A 32-byte message
//   is held as 8 x 32-bit words, in the same word format the decrypter emits.
//   Each message bit b expands to coefficient value Q/2 (bit set) or 0 (bit clear).
//   Coefficient c takes message bit (c mod 256). The coefficients stream out as
//   N sequential RAM writes.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   start      one-cycle pulse that begins encoding (accepted in IDLE/DONE)
//   done       high once all N coefficients are written; held until next start
//   msg_we     message word write enable (ignored while encoding)
//   msg_addr   message word index 0..7
//   msg_di     message word; byte 0 is the MSByte of word 0
//   poly_we    coefficient write strobe
//   poly_addr  coefficient index 0..N-1
//   poly_do    coefficient value, 0 or Q/2
module msg_encoder #(
    parameter int N  = 512,
    parameter int Q  = 12289,
    parameter int CW = 14,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          done,
    input  logic          msg_we,
    input  logic [2:0]    msg_addr,
    input  logic [31:0]   msg_di,
    output logic          poly_we,
    output logic [AW-1:0] poly_addr,
    output logic [CW-1:0] poly_do
);

    localparam logic [CW-1:0] HALF_Q = CW'(Q / 2);
    localparam logic [AW-1:0] LAST   = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] cnt;
    logic [31:0]   msg [8];
    logic          msg_bit;
    logic          enter_run;

    // Message store is deliberately not reset; the loaded words persist across runs.
    always_ff @(posedge clk) begin
        if (msg_we && state != RUN)
            msg[msg_addr] <= msg_di;
    end

    // Bit b = cnt[7:0] lives in byte b/8 = cnt[7:3].
    // That byte's word is cnt[7:5].
    // The byte sits at bit offset 8*(3 - cnt[4:3]) within the word.
    // 3 - x on two bits is ~x, so the in-word bit index is {~cnt[4:3], cnt[2:0]}.
    always_comb begin
        msg_bit = msg[cnt[7:5]][{~cnt[4:3], cnt[2:0]}];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == LAST) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_run = (state != RUN) && (state_nxt == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // All outputs are registered. The write for cnt lands one cycle after the cycle it is computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            done      <= 1'b0;
            poly_we   <= 1'b0;
            poly_addr <= '0;
            poly_do   <= '0;
        end else begin
            poly_we   <= 1'b0;
            poly_addr <= '0;
            poly_do   <= '0;
            if (state == RUN) begin
                poly_we   <= 1'b1;
                poly_addr <= cnt;
                poly_do   <= msg_bit ? HALF_Q : '0;
                cnt       <= cnt + AW'(1);
            end
            // done rises on the first cycle spent in DONE, after the last write is out.
            if (state == DONE)
                done <= 1'b1;
            if (enter_run) begin
                cnt  <= '0;
                done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_msg_encoder.sv
module tb_msg_encoder;

    localparam int NA = 512;
    localparam int NB = 1024;
    localparam int HQ = 6144;

    logic        clk = 1'b0;
    logic        rst, start, msg_we;
    logic [2:0]  msg_addr;
    logic [31:0] msg_di;

    logic        done_a, we_a, done_b, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [13:0] do_a, do_b;

    always #5 clk = ~clk;

    msg_encoder #(.N(NA), .Q(12289), .CW(14), .AW(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .done(done_a),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_di(msg_di),
        .poly_we(we_a), .poly_addr(addr_a), .poly_do(do_a)
    );

    msg_encoder #(.N(NB), .Q(12289), .CW(14), .AW(10)) dut_b (
        .clk(clk), .rst(rst), .start(start), .done(done_b),
        .msg_we(msg_we), .msg_addr(msg_addr), .msg_di(msg_di),
        .poly_we(we_b), .poly_addr(addr_b), .poly_do(do_b)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          wa = 0, wb = 0;
    int          q_a[$];
    int          q_b[$];
    logic [31:0] mdl [8];

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Reference mapping: byte i is word i/4, bits [31-8*(i%4) -: 8].
    // Message bit b is bit b%8 of byte b/8.
    function automatic int coef(input int c);
        int         b, i;
        logic [7:0] byt;
        logic [31:0] w;
        b   = c % 256;
        i   = b / 8;
        w   = mdl[i / 4] >> (24 - 8 * (i % 4));
        byt = w[7:0];
        return byt[b % 8] ? HQ : 0;
    endfunction

    task automatic push_exp();
        for (int c = 0; c < NB; c++) begin
            q_b.push_back(c * 65536 + coef(c));
            if (c < NA) q_a.push_back(c * 65536 + coef(c));
        end
    endtask

    // Monitors: pop the oldest expected write whenever a DUT presents one.
    always @(posedge clk) begin
        int e;
        #1;
        if (we_a) begin
            wa++;
            chk("a_expect_pending", int'(q_a.size() > 0), 1);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                chk("a_addr", int'(addr_a), e >>> 16);
                chk("a_data", int'(do_a), e & 16'hFFFF);
            end
        end else begin
            chk("a_idle_addr", int'(addr_a), 0);
            chk("a_idle_data", int'(do_a), 0);
        end
    end

    always @(posedge clk) begin
        int e;
        #1;
        if (we_b) begin
            wb++;
            chk("b_expect_pending", int'(q_b.size() > 0), 1);
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                chk("b_addr", int'(addr_b), e >>> 16);
                chk("b_data", int'(do_b), e & 16'hFFFF);
            end
        end else begin
            chk("b_idle_addr", int'(addr_b), 0);
            chk("b_idle_data", int'(do_b), 0);
        end
    end

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        msg_we   = 1'b1;
        msg_addr = 3'(a);
        msg_di   = d;
        mdl[a]   = d;
        @(negedge clk);
        msg_we = 1'b0;
    endtask

    task automatic load_all(input logic [31:0] d);
        for (int a = 0; a < 8; a++) wr(a, d);
    endtask

    // One full encode on both instances. Writes to the expected queues happen here.
    // With inject set, a second start and a message write are driven mid-run.
    // Both are expected to be ignored, so the reference model is left untouched.
    // With simul set, word 7 is written in the same cycle as start.
    task automatic run(input bit inject, input bit simul, input logic [31:0] sv);
        if (simul) mdl[7] = sv;
        push_exp();
        @(negedge clk);
        start = 1'b1;
        if (simul) begin
            msg_we = 1'b1; msg_addr = 3'd7; msg_di = sv;
        end
        wa = 0; wb = 0;
        @(negedge clk);
        start  = 1'b0;
        msg_we = 1'b0;
        chk("done_a_clears_on_start", int'(done_a), 0);
        chk("done_b_clears_on_start", int'(done_b), 0);
        chk("we_a_not_yet", int'(we_a), 0);
        for (int k = 1; k <= NB + 1; k++) begin
            @(negedge clk);
            if (inject && k == 50) start = 1'b1;
            if (inject && k == 51) start = 1'b0;
            if (inject && k == 60) begin
                msg_we = 1'b1; msg_addr = 3'd0; msg_di = ~mdl[0];
            end
            if (inject && k == 61) msg_we = 1'b0;
            if (k == NA) begin
                chk("a_last_write_we", int'(we_a), 1);
                chk("a_done_not_early", int'(done_a), 0);
            end
            if (k == NA + 1) begin
                chk("a_done_at_n_plus_1", int'(done_a), 1);
                chk("a_we_dropped", int'(we_a), 0);
                chk("a_write_count", wa, NA);
            end
            if (k == NB) begin
                chk("b_last_write_we", int'(we_b), 1);
                chk("b_done_not_early", int'(done_b), 0);
            end
            if (k == NB + 1) begin
                chk("b_done_at_n_plus_1", int'(done_b), 1);
                chk("b_we_dropped", int'(we_b), 0);
                chk("b_write_count", wb, NB);
            end
        end
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; msg_we = 1'b0; msg_addr = '0; msg_di = '0;
        repeat (3) @(negedge clk);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_we_a", int'(we_a), 0);
        chk("rst_done_b", int'(done_b), 0);
        rst = 1'b0;

        // Idle after reset: nothing may happen.
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_a || we_a || done_b || we_b) bad++;
        end
        chk("idle_20_quiet", bad, 0);

        // All-zero message.
        load_all(32'h0000_0000);
        run(1'b0, 1'b0, 32'h0);

        // Byte 0 bit 7 only: coefficients 7, 263, 519, 775 carry 6144.
        load_all(32'h0000_0000);
        wr(0, 32'h8000_0000);
        chk("hand_coef7", coef(7), HQ);
        chk("hand_coef263", coef(263), HQ);
        chk("hand_coef6", coef(6), 0);
        run(1'b0, 1'b0, 32'h0);

        // All ones. done must hold across idle cycles.
        // Then a run with a mid-run start and write that must be ignored.
        load_all(32'hFFFF_FFFF);
        run(1'b0, 1'b0, 32'h0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!done_a || !done_b) bad++;
        end
        chk("done_held_idle", bad, 0);
        wr(0, 32'h1234_5678);
        wr(5, 32'h00FF_0F0F);
        run(1'b1, 1'b0, 32'h0);

        // Random vector, with word 7 written in the same cycle as start.
        for (int a = 0; a < 7; a++) wr(a, $urandom());
        run(1'b0, 1'b1, $urandom());

        // Abort at the 100th write. The restart must produce a full image from address 0.
        push_exp();
        @(negedge clk);
        start = 1'b1;
        wa = 0; wb = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && wa < 100; k++) @(negedge clk);
        chk("abort_reached_100", wa, 100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_we_a_low", int'(we_a), 0);
        chk("abort_we_b_low", int'(we_b), 0);
        chk("abort_done_a_low", int'(done_a), 0);
        q_a.delete();
        q_b.delete();
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (we_a || we_b || done_a || done_b) bad++;
        end
        chk("abort_stays_quiet", bad, 0);
        run(1'b0, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
